// File: rtl/operand_fetch_pkg.sv
// Shared definitions for the operand fetch stage: RV32I opcodes, memory access sizes
// and the opcode-to-operand-use decode helpers also used by writeback.
package operand_fetch_pkg;

    localparam int M_WIDTH        = 8;
    localparam int REG_CNT        = 16;
    localparam int REG_ADDR_WIDTH = 4;
    localparam int OPCODE_WIDTH   = 7;

    localparam logic [OPCODE_WIDTH-1:0] OP_LUI         = 7'b0110111;
    localparam logic [OPCODE_WIDTH-1:0] OP_AIUPC       = 7'b0010111;
    localparam logic [OPCODE_WIDTH-1:0] OP_JAL         = 7'b1101111;
    localparam logic [OPCODE_WIDTH-1:0] OP_JALR        = 7'b1100111;
    localparam logic [OPCODE_WIDTH-1:0] OP_LOAD        = 7'b0000011;
    localparam logic [OPCODE_WIDTH-1:0] OP_STORE       = 7'b0100011;
    localparam logic [OPCODE_WIDTH-1:0] OP_BRANCH      = 7'b1100011;
    localparam logic [OPCODE_WIDTH-1:0] OP_INTEGER_IMM = 7'b0010011;
    localparam logic [OPCODE_WIDTH-1:0] OP_INTEGER     = 7'b0110011;

    typedef enum logic [1:0] {
        MEM_ACC_BYTE = 2'b00,
        MEM_ACC_HALF = 2'b01,
        MEM_ACC_WORD = 2'b10
    } mem_acc_t;

    typedef struct packed {
        logic [OPCODE_WIDTH-1:0]   op;
        logic [REG_ADDR_WIDTH-1:0] rs1;
        logic [REG_ADDR_WIDTH-1:0] rs2;
        logic [REG_ADDR_WIDTH-1:0] rd;
    } fetch_ins_t;

    function automatic logic uses_rs1(input logic [OPCODE_WIDTH-1:0] op);
        return op inside {OP_JALR, OP_LOAD, OP_STORE, OP_BRANCH, OP_INTEGER_IMM, OP_INTEGER};
    endfunction

    function automatic logic uses_rs2(input logic [OPCODE_WIDTH-1:0] op);
        return op inside {OP_STORE, OP_BRANCH, OP_INTEGER};
    endfunction

    function automatic logic writes_rd(input logic [OPCODE_WIDTH-1:0] op);
        return op inside {OP_LUI, OP_AIUPC, OP_JAL, OP_JALR, OP_LOAD, OP_INTEGER_IMM, OP_INTEGER};
    endfunction

    // Writeback asks the same question under its historical name.
    function automatic logic needs_writeback(input logic [OPCODE_WIDTH-1:0] op);
        return writes_rd(op);
    endfunction

endpackage

// File: rtl/operand_fetch_if.sv
// Decode/writeback-facing bundle of the operand fetch stage.
interface operand_fetch_if;
    import operand_fetch_pkg::*;

    logic                        en;
    logic                        flush;
    logic [OPCODE_WIDTH-1:0]     op;
    logic [REG_ADDR_WIDTH-1:0]   rs1;
    logic [REG_ADDR_WIDTH-1:0]   rs2;
    logic [REG_ADDR_WIDTH-1:0]   rd;
    logic [M_WIDTH*REG_CNT-1:0]  regs;
    logic                        wb_ready;
    logic [REG_ADDR_WIDTH-1:0]   wb_reg_addr;
    logic [M_WIDTH-1:0]          rs1_val;
    logic [M_WIDTH-1:0]          rs2_val;
    logic                        ready;
    logic [REG_CNT-1:0]          busy;

    modport master (
        output en, flush, op, rs1, rs2, rd, regs, wb_ready, wb_reg_addr,
        input  rs1_val, rs2_val, ready, busy
    );

    modport slave (
        input  en, flush, op, rs1, rs2, rd, regs, wb_ready, wb_reg_addr,
        output rs1_val, rs2_val, ready, busy
    );

endinterface

// File: rtl/operand_fetch_reg_scoreboard.sv
// Busy-register scoreboard: one bit per architectural register, set on issue and
// cleared on writeback completion. Register 0 can never become busy.
module operand_fetch_reg_scoreboard
    import operand_fetch_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      set_en,
    input  logic [REG_ADDR_WIDTH-1:0] set_addr,
    input  logic                      clr_en,
    input  logic [REG_ADDR_WIDTH-1:0] clr_addr,
    output logic [REG_CNT-1:0]        busy,
    output logic [REG_CNT-1:0]        eff_busy
);

    logic [REG_CNT-1:0] busy_q, busy_d;
    logic [REG_CNT-1:0] set_vec, clr_vec;

    // A set and a clear of the same register in one cycle leaves it busy.
    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (set_en) set_vec[set_addr] = 1'b1;
        if (clr_en) clr_vec[clr_addr] = 1'b1;
        eff_busy = busy_q & ~clr_vec;
        busy_d   = flush ? '0 : (eff_busy | set_vec);
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) busy_q <= '0;
        else     busy_q <= busy_d;
    end

    assign busy = busy_q;

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch: latches an instruction from decode, waits until its source registers
// are clean, then presents rs1/rs2 from the register file with a one-cycle ready pulse.
module operand_fetch
    import operand_fetch_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    operand_fetch_if.slave bus
);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_CHECK = 1'b1;

    logic [0:0]         state_q, state_d;
    fetch_ins_t         ins_q, ins_d;
    logic [M_WIDTH-1:0] rs1_val_q, rs1_val_d;
    logic [M_WIDTH-1:0] rs2_val_q, rs2_val_d;
    logic               ready_q, ready_d;

    logic [REG_CNT-1:0] busy_vec, eff_busy;
    logic [M_WIDTH-1:0] rs1_slice, rs2_slice;
    logic               hazard, issue, set_en;

    assign rs1_slice = bus.regs[M_WIDTH*ins_q.rs1 +: M_WIDTH];
    assign rs2_slice = bus.regs[M_WIDTH*ins_q.rs2 +: M_WIDTH];

    // A completion arriving this cycle already frees its register, so no bypass is needed:
    // writeback has updated regs before it strobes.
    assign hazard = (uses_rs1(ins_q.op) && eff_busy[ins_q.rs1]) ||
                    (uses_rs2(ins_q.op) && eff_busy[ins_q.rs2]);
    assign issue  = (state_q == S_CHECK) && !hazard && !bus.flush;
    assign set_en = issue && writes_rd(ins_q.op) && (ins_q.rd != '0);

    operand_fetch_reg_scoreboard u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .flush    (bus.flush),
        .set_en   (set_en),
        .set_addr (ins_q.rd),
        .clr_en   (bus.wb_ready),
        .clr_addr (bus.wb_reg_addr),
        .busy     (busy_vec),
        .eff_busy (eff_busy)
    );

    always_comb begin
        state_d   = state_q;
        ins_d     = ins_q;
        rs1_val_d = rs1_val_q;
        rs2_val_d = rs2_val_q;
        ready_d   = 1'b0;
        if (bus.flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.en) begin
                        ins_d.op  = bus.op;
                        ins_d.rs1 = bus.rs1;
                        ins_d.rs2 = bus.rs2;
                        ins_d.rd  = bus.rd;
                        state_d   = S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (issue) begin
                        rs1_val_d = uses_rs1(ins_q.op) ? rs1_slice : '0;
                        rs2_val_d = uses_rs2(ins_q.op) ? rs2_slice : '0;
                        ready_d   = 1'b1;
                        state_d   = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            ins_q     <= '0;
            rs1_val_q <= '0;
            rs2_val_q <= '0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            ins_q     <= ins_d;
            rs1_val_q <= rs1_val_d;
            rs2_val_q <= rs2_val_d;
            ready_q   <= ready_d;
        end
    end

    assign bus.rs1_val = rs1_val_q;
    assign bus.rs2_val = rs2_val_q;
    assign bus.ready   = ready_q;
    assign bus.busy    = busy_vec;

endmodule
